// File: rtl/mux4_rr_arbiter_if.sv
// Bundle of request, grant and datapath-handshake signals between the
// requesters/downstream side (master) and the round-robin arbiter (slave).
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] last;
  logic       out_ready;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       out_valid;
  logic       busy;
  logic       timeout;

  modport slave (
    input  req,
    input  last,
    input  out_ready,
    output gnt,
    output sel,
    output out_valid,
    output busy,
    output timeout
  );

  modport master (
    output req,
    output last,
    output out_ready,
    input  gnt,
    input  sel,
    input  out_valid,
    input  busy,
    input  timeout
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a shared 4:1 datapath: one burst per grant, one IDLE gap.
// Optional watchdog release is built in when ARB_TIMEOUT_EN is defined.
module mux4_rr_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  mux4_rr_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;

  logic [1:0] winner;
  logic       found;
  logic       in_busy;
  logic       out_valid;
  logic       xfer;
  logic       normal_rel;
  logic       expire;
  logic       rel;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mux4_rr_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  // Search starts one past the last released owner, so offset 4 (wraps to 0)
  // revisits that owner only after everyone else.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!found && bus.req[ptr_q + 2'(k)]) begin
        winner = ptr_q + 2'(k);
        found  = 1'b1;
      end
    end
  end

  assign in_busy    = (state_q == BUSY);
  assign out_valid  = in_busy && bus.req[sel_q];
  assign xfer       = out_valid && bus.out_ready;
  assign normal_rel = in_busy && ((xfer && bus.last[sel_q]) || !bus.req[sel_q]);
  assign rel        = normal_rel || expire;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire = in_busy && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Count is 1 on the first BUSY cycle; any release returns it to 0.
  always_comb begin
    cnt_d = '0;
    if (in_busy && !rel) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!in_busy && found) begin
      cnt_d = CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A coincident normal release wins, and reset suppresses the pulse.
  assign bus.timeout = expire && !normal_rel && !rst;
`else
  assign expire      = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned; otherwise synthesis infers a latch to hold its old value.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (found) begin
          state_d = BUSY;
          gnt_d   = 4'b0001 << winner;
          sel_d   = winner;
        end
      end
      BUSY: begin
        if (rel) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = sel_q;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // NOTE: reset is synchronous, so it is tested only inside the clocked
  // branch and rst is deliberately absent from the sensitivity list.
  // ptr starts at 3 so requester 0 is first in line after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= 2'd3;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from
      // values sampled at the same edge, independent of statement order.
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = in_busy;
  assign bus.out_valid = out_valid;

  a_gnt_onehot_busy: assert property (@(posedge clk) disable iff (rst)
    in_busy |-> $onehot(gnt_q));
  a_gnt_zero_idle: assert property (@(posedge clk) disable iff (rst)
    !in_busy |-> (gnt_q == 4'b0000));

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios then random
// traffic, all compared every cycle against a behavioural model of the rules.
module tb_mux4_rr_arbiter;
  localparam int TMO = 16;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: who owns the path, who owned it last, how long it has.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_last  = 3;
  int m_age   = 0;
  int grants[$];

  int exp_rr   [5] = '{0, 1, 2, 3, 0};
  int exp_wrap [3] = '{3, 0, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, want);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic o);
    bus.req       = r;
    bus.last      = l;
    bus.out_ready = o;
    #1;
  endtask

  // The owner gives up when it stops requesting or completes its last beat.
  function automatic bit owner_done();
    return !bus.req[m_owner] || (bus.out_ready && bus.last[m_owner]);
  endfunction

  // Compare every output with the model, then advance the model across the
  // next rising edge and move to the following falling edge.
  task automatic cycle();
    bit done    = owner_done();
    bit expired = TMO_EN && (m_age >= TMO);
    bit hit     = 1'b0;
    chk("gnt", 32'(bus.gnt), m_busy ? (32'd1 << m_owner) : 32'd0);
    chk("sel", 32'(bus.sel), 32'(m_owner));
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("out_valid", 32'(bus.out_valid), 32'(m_busy && bus.req[m_owner]));
    chk("timeout", 32'(bus.timeout), 32'(m_busy && expired && !done && !rst));
    if (rst) begin
      m_busy  = 1'b0;
      m_owner = 0;
      m_last  = 3;
      m_age   = 0;
    end else if (!m_busy) begin
      for (int k = 1; k <= 4; k++) begin
        if (!hit && bus.req[(m_last + k) % 4]) begin
          hit     = 1'b1;
          m_owner = (m_last + k) % 4;
        end
      end
      if (hit) begin
        m_busy = 1'b1;
        m_age  = 1;
        grants.push_back(m_owner);
      end
    end else if (done || expired) begin
      m_busy = 1'b0;
      m_last = m_owner;
      m_age  = 0;
    end else begin
      m_age++;
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] r_rand;
    int n_hold;

    bus.req = '0;
    bus.last = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // Reset state
    drive(4'b0000, 4'b0000, 1'b0);
    cycle();
    drive(4'b1111, 4'b1111, 1'b1);
    cycle();

    // Single requester, three beats, last on the third
    rst = 1'b0;
    drive(4'b0000, 4'b0000, 1'b1);
    cycle();
    drive(4'b0001, 4'b0000, 1'b1);
    chk("s1_idle_gnt", 32'(bus.gnt), 32'h0);
    cycle();
    drive(4'b0001, 4'b0000, 1'b1);
    chk("s1_gnt", 32'(bus.gnt), 32'h1);
    chk("s1_sel", 32'(bus.sel), 32'h0);
    cycle();
    drive(4'b0001, 4'b0000, 1'b1);
    cycle();
    drive(4'b0001, 4'b0001, 1'b1);
    chk("s1_busy_beat3", 32'(bus.busy), 32'h1);
    cycle();
    drive(4'b0000, 4'b0000, 1'b0);
    chk("s1_released", 32'(bus.gnt), 32'h0);
    cycle();

    // Fairness: all requesting, one-beat bursts
    rst = 1'b1;
    drive(4'b0000, 4'b0000, 1'b0);
    cycle();
    rst = 1'b0;
    grants.delete();
    for (int i = 0; i < 10; i++) begin
      drive(4'b1111, 4'b1111, 1'b1);
      if (i % 2 == 1) chk("rr_gnt", 32'(bus.gnt), 32'd1 << exp_rr[i / 2]);
      else            chk("rr_gap", 32'(bus.gnt), 32'h0);
      cycle();
    end
    chk("rr_count", 32'(grants.size()), 32'd5);
    foreach (exp_rr[i]) chk("rr_order", 32'(grants[i]), 32'(exp_rr[i]));

    // Wrap from ptr = 2 with requesters 0, 1, 3
    rst = 1'b1;
    drive(4'b0000, 4'b0000, 1'b0);
    cycle();
    rst = 1'b0;
    drive(4'b0100, 4'b0100, 1'b1);
    cycle();
    drive(4'b0100, 4'b0100, 1'b1);
    chk("wrap_gnt2", 32'(bus.gnt), 32'h4);
    cycle();
    grants.delete();
    for (int i = 0; i < 6; i++) begin
      drive(4'b1011, 4'b1111, 1'b1);
      cycle();
    end
    chk("wrap_count", 32'(grants.size()), 32'd3);
    foreach (exp_wrap[i]) chk("wrap_order", 32'(grants[i]), 32'(exp_wrap[i]));

    // Backpressure: last held with out_ready low must not release
    rst = 1'b1;
    drive(4'b0000, 4'b0000, 1'b0);
    cycle();
    rst = 1'b0;
    drive(4'b0010, 4'b0000, 1'b0);
    cycle();
    for (int n = 0; n < 5; n++) begin
      drive(4'b0010, 4'b0010, 1'b0);
      chk("bp_gnt", 32'(bus.gnt), 32'h2);
      chk("bp_valid", 32'(bus.out_valid), 32'h1);
      cycle();
    end
    drive(4'b0010, 4'b0010, 1'b1);
    chk("bp_valid_ready", 32'(bus.out_valid), 32'h1);
    cycle();
    drive(4'b0000, 4'b0000, 1'b0);
    chk("bp_release_gnt", 32'(bus.gnt), 32'h0);
    chk("bp_release_busy", 32'(bus.busy), 32'h0);
    cycle();

    // Abandon by requester 2; ptr must then favour requester 3
    rst = 1'b1;
    drive(4'b0000, 4'b0000, 1'b0);
    cycle();
    rst = 1'b0;
    drive(4'b0100, 4'b0000, 1'b0);
    cycle();
    drive(4'b0100, 4'b0000, 1'b0);
    chk("ab_gnt", 32'(bus.gnt), 32'h4);
    cycle();
    drive(4'b0000, 4'b0000, 1'b0);
    chk("ab_valid_drop", 32'(bus.out_valid), 32'h0);
    cycle();
    drive(4'b0000, 4'b0000, 1'b0);
    chk("ab_idle_gnt", 32'(bus.gnt), 32'h0);
    chk("ab_sel_held", 32'(bus.sel), 32'h2);
    cycle();
    drive(4'b1111, 4'b0000, 1'b0);
    cycle();
    drive(4'b1111, 4'b0000, 1'b0);
    chk("ab_next_gnt", 32'(bus.gnt), 32'h8);

    // Reset in the middle of that BUSY
    rst = 1'b1;
    cycle();
    drive(4'b1111, 4'b0000, 1'b0);
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_sel", 32'(bus.sel), 32'h0);
    chk("rst_timeout", 32'(bus.timeout), 32'h0);
    cycle();
    rst = 1'b0;
    drive(4'b1111, 4'b0000, 1'b0);
    cycle();
    drive(4'b1111, 4'b0000, 1'b0);
    chk("rst_first_gnt", 32'(bus.gnt), 32'h1);
    cycle();

    // Watchdog: grant held with out_ready low
    rst = 1'b1;
    drive(4'b0000, 4'b0000, 1'b0);
    cycle();
    rst = 1'b0;
    drive(4'b0001, 4'b0000, 1'b0);
    cycle();
    n_hold = TMO_EN ? TMO : 100;
    for (int n = 1; n <= n_hold; n++) begin
      drive(4'b0001, 4'b0001, 1'b0);
      chk("wd_busy", 32'(bus.busy), 32'h1);
      chk("wd_timeout", 32'(bus.timeout), 32'(TMO_EN && n == TMO));
      cycle();
    end
    drive(4'b0001, 4'b0001, 1'b0);
    chk("wd_after_gnt", 32'(bus.gnt), TMO_EN ? 32'h0 : 32'h1);
    cycle();

    // Normal release coinciding with the final watchdog cycle
    rst = 1'b1;
    drive(4'b0000, 4'b0000, 1'b0);
    cycle();
    rst = 1'b0;
    drive(4'b0001, 4'b0000, 1'b0);
    cycle();
    for (int n = 1; n < TMO; n++) begin
      drive(4'b0001, 4'b0001, 1'b0);
      cycle();
    end
    drive(4'b0001, 4'b0001, 1'b1);
    chk("coinc_timeout", 32'(bus.timeout), 32'h0);
    chk("coinc_valid", 32'(bus.out_valid), 32'h1);
    cycle();
    drive(4'b0000, 4'b0000, 1'b0);
    chk("coinc_gnt", 32'(bus.gnt), 32'h0);
    cycle();

    // Random traffic with sticky requests and occasional reset
    r_rand = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 3) == 0) r_rand = 4'($urandom);
      drive(r_rand, 4'($urandom) & 4'($urandom), $urandom_range(0, 3) != 0);
      cycle();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
